// File: rtl/mprj_stimulus_checker.sv
//=============================================================================
// Module      : mprj_stimulus_checker
// Description : On-chip monitor for the user-project IO stimulus handshake:
//               start signature, N capture/compare rounds, pass signature.
// Revision    : 1.0 - initial release
//=============================================================================
`timescale 1ns/1ps
`default_nettype none

module mprj_stimulus_checker #(
    parameter int               CHK_W     = 16,
    parameter int               STS_W     = 4,
    parameter int               CNT_W     = 8,
    parameter logic [CHK_W-1:0] START_SIG = 16'hAB40,
    parameter logic [CHK_W-1:0] PASS_SIG  = 16'hAB51,
    parameter logic [STS_W-1:0] STS_A     = 4'hA,
    parameter logic [STS_W-1:0] STS_B     = 4'h5,
    parameter int               N_ROUNDS  = 2,
    parameter int               TIMEOUT   = 100000,
    parameter int               TO_W      = 17
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             enable,
    input  logic [CHK_W-1:0] checkbits,
    input  logic [STS_W-1:0] status,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] first_val,
    output logic [CNT_W-1:0] last_val,
    output logic [3:0]       round_cnt
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_START = 3'd1,
        S_WAIT_A     = 3'd2,
        S_WAIT_B     = 3'd3,
        S_WAIT_PASS  = 3'd4,
        S_DONE       = 3'd5
    } t_state;

    localparam logic [1:0]      c_fail_none    = 2'd0;
    localparam logic [1:0]      c_fail_timeout = 2'd1;
    localparam logic [1:0]      c_fail_stuck   = 2'd2;
    localparam logic [1:0]      c_fail_abort   = 2'd3;
    localparam logic [TO_W-1:0] c_to_last      = TO_W'(TIMEOUT - 1);
    localparam logic [3:0]      c_rounds       = 4'(N_ROUNDS);

    t_state           r_state;
    logic [CHK_W-1:0] r_chk_s1, r_chk_s2;
    logic [STS_W-1:0] r_sts_s1, r_sts_s2;
    logic             r_enable_d;
    logic [TO_W-1:0]  r_timer;
    logic             r_busy, r_done, r_pass;
    logic [1:0]       r_fail_code;
    logic [CNT_W-1:0] r_first_val, r_last_val;
    logic [3:0]       r_round_cnt;

    logic             w_enable_rise;
    logic             w_timeout;
    logic             w_step;
    logic [CNT_W-1:0] w_cnt;
    logic [3:0]       w_round_next;

    assign w_enable_rise = enable & ~r_enable_d;
    assign w_timeout     = (r_timer == c_to_last);
    assign w_cnt         = r_chk_s2[CNT_W-1:0];
    assign w_round_next  = r_round_cnt + 4'd1;

    // A state-advancing event always outranks a coincident timeout
    assign w_step = ((r_state == S_WAIT_START) && (r_chk_s2 == START_SIG)) ||
                    ((r_state == S_WAIT_A)     && (r_sts_s2 == STS_A))     ||
                    ((r_state == S_WAIT_B)     && (r_sts_s2 == STS_B))     ||
                    ((r_state == S_WAIT_PASS)  && (r_chk_s2 == PASS_SIG));

    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_chk_s1    <= '0;
            r_chk_s2    <= '0;
            r_sts_s1    <= '0;
            r_sts_s2    <= '0;
            // Held high so an enable already asserted through reset cannot re-arm
            r_enable_d  <= 1'b1;
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_code <= c_fail_none;
            r_first_val <= '0;
            r_last_val  <= '0;
            r_round_cnt <= '0;
        end else begin
            r_chk_s1   <= checkbits;
            r_chk_s2   <= r_chk_s1;
            r_sts_s1   <= status;
            r_sts_s2   <= r_sts_s1;
            r_enable_d <= enable;
            if (r_busy) begin
                r_timer <= r_timer + 1'b1;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_enable_rise) begin
                        r_state     <= S_WAIT_START;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_fail_code <= c_fail_none;
                        r_first_val <= '0;
                        r_last_val  <= '0;
                        r_round_cnt <= '0;
                        r_timer     <= '0;
                    end
                end
                default: begin
                    if (!enable) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_fail_code <= c_fail_abort;
                    end else if (w_step) begin
                        case (r_state)
                            S_WAIT_START: r_state <= S_WAIT_A;
                            S_WAIT_A: begin
                                r_last_val <= w_cnt;
                                if (r_round_cnt == 4'd0) begin
                                    r_first_val <= w_cnt;
                                end
                                r_state <= S_WAIT_B;
                            end
                            S_WAIT_B: begin
                                if (w_cnt == r_last_val) begin
                                    r_state     <= S_DONE;
                                    r_busy      <= 1'b0;
                                    r_done      <= 1'b1;
                                    r_fail_code <= c_fail_stuck;
                                end else begin
                                    r_round_cnt <= w_round_next;
                                    r_state     <= (w_round_next == c_rounds) ? S_WAIT_PASS : S_WAIT_A;
                                end
                            end
                            S_WAIT_PASS: begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_pass  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end else if (w_timeout) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_fail_code <= c_fail_timeout;
                    end
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_code = r_fail_code;
    assign first_val = r_first_val;
    assign last_val  = r_last_val;
    assign round_cnt = r_round_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mprj_stimulus_checker.sv
//=============================================================================
// Module      : tb_mprj_stimulus_checker
// Description : Directed self-checking bench for mprj_stimulus_checker.
// Revision    : 1.0 - initial release
//=============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mprj_stimulus_checker;

    localparam logic [15:0] c_start = 16'hAB40;
    localparam logic [15:0] c_pass  = 16'hAB51;
    localparam logic [3:0]  c_sts_a = 4'hA;
    localparam logic [3:0]  c_sts_b = 4'h5;

    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] checkbits = 16'h0000;
    logic [3:0]  status = 4'h0;
    logic        busy, done, pass;
    logic [1:0]  fail_code;
    logic [7:0]  first_val, last_val;
    logic [3:0]  round_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int cyc_arm = 0;

    mprj_stimulus_checker #(
        .CHK_W(16), .STS_W(4), .CNT_W(8),
        .START_SIG(16'hAB40), .PASS_SIG(16'hAB51),
        .STS_A(4'hA), .STS_B(4'h5),
        .N_ROUNDS(2), .TIMEOUT(50), .TO_W(6)
    ) dut (
        .clock(clock), .resetb(resetb), .enable(enable),
        .checkbits(checkbits), .status(status),
        .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
        .first_val(first_val), .last_val(last_val), .round_cnt(round_cnt)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Pins need three edges to reach a registered output
    task automatic step(input logic [15:0] chk, input logic [3:0] sts);
        checkbits = chk;
        status    = sts;
        repeat (3) tick();
    endtask

    task automatic arm();
        checkbits = 16'h0000;
        status    = 4'h0;
        enable    = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        tick();
        cyc_arm = cyc;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        enable = 1'b0;
        repeat (2) tick();
        n_vec++; if ({busy, done, pass} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {busy, done, pass}); end
        n_vec++; if ({fail_code, first_val, last_val, round_cnt} !== 22'h0) begin n_err++; $display("FAIL reset_vals: got %h expected 0", {fail_code, first_val, last_val, round_cnt}); end
        resetb = 1'b1;
        tick();
    endtask

    task automatic test_pass_run();
        arm();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL arm_busy: got %b expected 1", busy); end
        step(c_start, 4'h0);
        step({8'h00, 8'd12}, c_sts_a);
        step({8'h00, 8'd13}, c_sts_b);
        step({8'h00, 8'd13}, c_sts_a);
        step({8'h00, 8'd14}, c_sts_b);
        checkbits = c_pass;
        repeat (2) tick();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL pass_latency_early: got done=%b expected 0", done); end
        tick();
        n_vec++; if ({done, pass, busy} !== 3'b110) begin n_err++; $display("FAIL pass_flags: got %b expected 110", {done, pass, busy}); end
        n_vec++; if (round_cnt !== 4'd2) begin n_err++; $display("FAIL pass_rounds: got %0d expected 2", round_cnt); end
        n_vec++; if (first_val !== 8'd12) begin n_err++; $display("FAIL pass_first: got %0d expected 12", first_val); end
        n_vec++; if (last_val !== 8'd13) begin n_err++; $display("FAIL pass_last: got %0d expected 13", last_val); end
        n_vec++; if (fail_code !== 2'd0) begin n_err++; $display("FAIL pass_code: got %0d expected 0", fail_code); end
    endtask

    task automatic test_stuck();
        arm();
        step(c_start, 4'h0);
        step({8'h00, 8'd5}, c_sts_a);
        step({8'h00, 8'd6}, c_sts_b);
        step({8'h00, 8'd37}, c_sts_a);
        step({8'h00, 8'd37}, c_sts_b);
        n_vec++; if ({done, pass, busy} !== 3'b100) begin n_err++; $display("FAIL stuck_flags: got %b expected 100", {done, pass, busy}); end
        n_vec++; if (fail_code !== 2'd2) begin n_err++; $display("FAIL stuck_code: got %0d expected 2", fail_code); end
        n_vec++; if (round_cnt !== 4'd1) begin n_err++; $display("FAIL stuck_rounds: got %0d expected 1", round_cnt); end
        n_vec++; if (last_val !== 8'd37) begin n_err++; $display("FAIL stuck_last: got %0d expected 37", last_val); end
        n_vec++; if (first_val !== 8'd5) begin n_err++; $display("FAIL stuck_first: got %0d expected 5", first_val); end
    endtask

    task automatic test_timeout();
        arm();
        repeat (49) tick();
        n_vec++; if ({done, busy} !== 2'b01) begin n_err++; $display("FAIL timeout_early: got done,busy=%b expected 01", {done, busy}); end
        tick();
        n_vec++; if ({done, busy} !== 2'b10) begin n_err++; $display("FAIL timeout_flags: got done,busy=%b expected 10", {done, busy}); end
        n_vec++; if (fail_code !== 2'd1) begin n_err++; $display("FAIL timeout_code: got %0d expected 1", fail_code); end
    endtask

    task automatic test_abort();
        arm();
        step(c_start, 4'h0);
        step({8'h00, 8'd20}, c_sts_a);
        enable = 1'b0;
        tick();
        n_vec++; if ({done, busy, pass} !== 3'b100) begin n_err++; $display("FAIL abort_flags: got %b expected 100", {done, busy, pass}); end
        n_vec++; if (fail_code !== 2'd3) begin n_err++; $display("FAIL abort_code: got %0d expected 3", fail_code); end
        enable = 1'b1;
        tick();
        n_vec++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL rearm_flags: got busy,done=%b expected 10", {busy, done}); end
        n_vec++; if ({round_cnt, fail_code} !== 6'h0) begin n_err++; $display("FAIL rearm_clear: got %h expected 0", {round_cnt, fail_code}); end
    endtask

    task automatic test_reset_mid();
        arm();
        step(c_start, 4'h0);
        step({8'h00, 8'd1}, c_sts_a);
        step({8'h00, 8'd2}, c_sts_b);
        step({8'h00, 8'd2}, c_sts_a);
        step({8'h00, 8'd3}, c_sts_b);
        n_vec++; if ({busy, round_cnt} !== 5'b1_0010) begin n_err++; $display("FAIL waitpass_state: got %b expected 10010", {busy, round_cnt}); end
        resetb = 1'b0;
        tick();
        resetb = 1'b1;
        n_vec++; if ({busy, done, pass, fail_code, first_val, last_val, round_cnt} !== 25'h0) begin n_err++; $display("FAIL midreset_outputs: got %h expected 0", {busy, done, pass, fail_code, first_val, last_val, round_cnt}); end
        step(c_pass, 4'h0);
        repeat (3) tick();
        n_vec++; if ({done, pass} !== 2'b00) begin n_err++; $display("FAIL midreset_nopass: got %b expected 00", {done, pass}); end
    endtask

    task automatic test_wrap_glitch_race();
        arm();
        step(c_start, 4'h0);
        step({8'h00, 8'hFF}, c_sts_a);
        step({8'h00, 8'hFF}, 4'h3);
        n_vec++; if ({busy, round_cnt} !== 5'b1_0000) begin n_err++; $display("FAIL glitch_ignored: got %b expected 10000", {busy, round_cnt}); end
        step({8'h00, 8'h00}, c_sts_b);
        n_vec++; if ({busy, round_cnt} !== 5'b1_0001) begin n_err++; $display("FAIL wrap_changed: got %b expected 10001", {busy, round_cnt}); end
        step({8'h00, 8'h10}, c_sts_a);
        step({8'h00, 8'h11}, c_sts_b);
        checkbits = 16'h0000;
        while ((cyc - cyc_arm) < 47) tick();
        checkbits = c_pass;
        repeat (2) tick();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL race_early: got done=%b expected 0", done); end
        tick();
        n_vec++; if ({done, pass} !== 2'b11) begin n_err++; $display("FAIL race_pass: got %b expected 11", {done, pass}); end
        n_vec++; if (fail_code !== 2'd0) begin n_err++; $display("FAIL race_code: got %0d expected 0", fail_code); end
        n_vec++; if (first_val !== 8'hFF) begin n_err++; $display("FAIL wrap_first: got %h expected ff", first_val); end
    endtask

    initial begin
        test_reset();
        test_pass_run();
        test_stuck();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_wrap_glitch_race();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
